// File: rtl/apb_requester_if.sv
// Command/response stream plus APB bus signals of the APB requester.
// The master modport is the requester's view. The slave modport is the view of the command source and the APB target.
interface apb_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_requester.sv
// APB initiator: accepts one command at a time and runs it as a SETUP/ACCESS transfer.
// It returns one held response per command and aborts an ACCESS phase that waits too long.
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  apb_requester_if.master bus
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              cmd_ready;

  // A pending response blocks new commands, so a stalled consumer stalls the bus.
  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          pwrite_d   = bus.cmd_write;
          paddr_d    = bus.cmd_addr;
          pwdata_d   = bus.cmd_wdata;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          // Abort: the bus goes idle; a late pready then finds the FSM in IDLE.
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB initiator that turns a valid/ready command stream into single APB transfers on the bus side. It returns one response (read data, error flags) per command. It drives the bus used by the team's APB RAM slaves and is the block those slaves are tested against. It allows one outstanding transfer, enforces strict SETUP→ACCESS sequencing and has a wait-state timeout.

Parameters:
ADDR_W, 32, width of paddr / cmd_addr
DATA_W, 32, width of pwdata / prdata / cmd_wdata / rsp_rdata
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 = no timeout

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response present, held until rsp_ready
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes, errors and timeouts)
rsp_err  out  1  pslverr seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset (preset=1, async): state IDLE; psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0; paddr, pwdata and rsp_rdata are 0; wait counter is 0. Reset mid-transfer aborts at once: the bus drops to idle and no response is produced.
- All APB outputs and rsp_* outputs are registered. cmd_ready = (state==IDLE) & !rsp_valid, combinational from registers only.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: psel=0, penable=0. On a command handshake, latch write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP (exactly 1 cycle): psel=1, penable=0. Go to ACCESS.
  - ACCESS: psel=1, penable=1. paddr, pwrite and pwdata stay stable until the transfer ends.
    - pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0. Set rsp_valid and go to IDLE; psel and penable read 0 on the next cycle.
    - pready=0: increment the wait counter.
    - If TIMEOUT≠0 and the counter equals TIMEOUT-1 while pready=0: abort. Set rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE. Late pready after an abort is ignored.
  - The wait counter clears on entry to SETUP. Its width is enough to hold TIMEOUT.
- Latency, zero-wait slave: handshake at edge T → SETUP T+1 → ACCESS T+2 → rsp_valid high T+3. Each pready-low cycle adds 1.
- Response slot:
  - rsp_valid and its data stay stable until rsp_ready.
  - No new command is accepted while rsp_valid=1, so a stalled consumer stalls the bus.
  - rsp_valid & rsp_ready in IDLE clears rsp_valid. cmd_ready rises the next cycle, giving a minimum of 4 cycles per transfer.
- pslverr is sampled only when pready=1 in ACCESS. prdata is ignored on writes and on pslverr=1 (rsp_rdata=0).
- Address range is not checked here; out-of-range handling belongs to the slave.
- The address is passed through unmodified; paddr is never decremented or wrapped.

Test Plan:
- Write addr 0x5, data 0xDEADBEEF to a zero-wait slave → SETUP one cycle (psel=1, penable=0), ACCESS one cycle. rsp_valid=1 three cycles after the handshake with rsp_err=0, rsp_rdata=0. A read of 0x5 then returns rsp_rdata=0xDEADBEEF.
- Read addr 0x28 (out of range) with the slave returning pslverr=1, pready=1 → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Slave inserts 3 wait states on a read of 0x1F returning 0x12345678 → paddr stable for 4 ACCESS cycles; rsp_valid 6 cycles after the handshake; rsp_rdata=0x12345678.
- TIMEOUT=4, pready held 0 → abort after 4 ACCESS cycles with rsp_err=1, rsp_timeout=1, psel=0. A pready pulse after the abort is ignored.
- Hold rsp_ready=0 for 5 cycles with a second command pending → cmd_ready=0 and psel=0 throughout. Second SETUP starts 2 cycles after rsp_ready rises; the first response is unchanged while held.
- Assert preset during ACCESS → psel, penable and rsp_valid go to 0 without waiting for a clock edge. After release, cmd_ready=1 and the next command runs normally.
